led_fade_pwm_driver: RTL and testbench

Output stage between the LED blink/pattern logic and the active-low LED pins of the 12 MHz board. It takes two logical on/off requests (blue, amber) and drives the pins with 8-bit PWM. In hard mode it switches instantly. In fade mode it ramps brightness up or down over about one second, so a 1 Hz toggle source becomes a breathing effect.

---
 rtl/led_fade_pwm_driver.sv | 89 ++++++++
 tb/tb_led_fade_pwm_driver.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_pwm_driver.sv
// Two-channel active-low LED driver: 8-bit PWM with either instant on/off or
// a saturating brightness ramp paced by a free-running step prescaler.
module led_fade_pwm_driver #(
  parameter int unsigned STEP_CYCLES = 46875
) (
  input  logic clk,
  input  logic rst_n,
  input  logic blue_req,
  input  logic amber_req,
  input  logic fade_en,
  output logic led_blue_n,
  output logic led_amber_n,
  output logic fade_busy
);

  typedef enum logic [1:0] {OFF, RISE, ON, FALL} fade_state_t;

  localparam logic [23:0] STEP_LAST = 24'(STEP_CYCLES - 1);

  logic [23:0]  presc;
  logic         step;
  logic [7:0]   pwm_cnt;
  logic [1:0]   req;
  logic [1:0]   lit;
  logic [7:0]   level     [2];
  logic [7:0]   level_nxt [2];
  fade_state_t  state     [2];
  fade_state_t  state_nxt [2];

  function automatic logic [7:0] sat_step(input logic [7:0] lvl, input fade_state_t st);
    logic [7:0] res;
    res = lvl;
    if (st == RISE && lvl != 8'hFF) res = lvl + 8'd1;
    if (st == FALL && lvl != 8'h00) res = lvl - 8'd1;
    return res;
  endfunction

  assign step = (presc == STEP_LAST);
  assign req  = {amber_req, blue_req};

  // The ON/OFF decision looks at the level this edge will commit, so the
  // terminal state is entered in the same cycle the level saturates.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      level_nxt[i] = level[i];
      state_nxt[i] = state[i];
      lit[i]       = (level[i] == 8'hFF) || (pwm_cnt < level[i]);
      if (!fade_en) begin
        level_nxt[i] = req[i] ? 8'hFF : 8'h00;
        state_nxt[i] = req[i] ? ON : OFF;
      end else begin
        if (step) level_nxt[i] = sat_step(level[i], state[i]);
        unique case (state[i])
          OFF:  state_nxt[i] = req[i] ? RISE : OFF;
          RISE: state_nxt[i] = !req[i] ? FALL : ((level_nxt[i] == 8'hFF) ? ON : RISE);
          ON:   state_nxt[i] = req[i] ? ON : FALL;
          FALL: state_nxt[i] = req[i] ? RISE : ((level_nxt[i] == 8'h00) ? OFF : FALL);
        endcase
      end
    end
  end

  // Register stage: prescaler, PWM counter, channel state and pin outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc       <= '0;
      pwm_cnt     <= '0;
      for (int i = 0; i < 2; i++) begin
        level[i] <= '0;
        state[i] <= OFF;
      end
      led_blue_n  <= 1'b1;
      led_amber_n <= 1'b1;
      fade_busy   <= 1'b0;
    end else begin
      presc       <= step ? 24'd0 : presc + 24'd1;
      pwm_cnt     <= pwm_cnt + 8'd1;
      for (int i = 0; i < 2; i++) begin
        level[i] <= level_nxt[i];
        state[i] <= state_nxt[i];
      end
      led_blue_n  <= ~lit[0];
      led_amber_n <= ~lit[1];
      fade_busy   <= (state[0] == RISE) || (state[0] == FALL) ||
                     (state[1] == RISE) || (state[1] == FALL);
    end
  end

endmodule

// File: tb/tb_led_fade_pwm_driver.sv
// Scoreboard bench for led_fade_pwm_driver: a cycle model predicts the pins and
// fade_busy after every edge; directed phases add latency and duty checks.
module tb_led_fade_pwm_driver;

  localparam int SC   = 4;
  localparam int SC_S = 300;

  logic clk = 1'b0;
  logic rst_n, blue_req, amber_req, fade_en;
  logic led_blue_n, led_amber_n, fade_busy;
  logic slow_rst_n, slow_req;
  logic slow_blue_n, slow_amber_n, slow_busy;

  int n_vec = 0;
  int n_err = 0;

  logic [2:0] sb_q[$];

  int   m_pre = 0, m_pwm = 0;
  int   m_lvl[2] = '{0, 0};
  int   m_st[2]  = '{0, 0};   // 0 OFF, 1 RISE, 2 ON, 3 FALL
  logic m_led[2] = '{1'b1, 1'b1};
  logic m_busy   = 1'b0;

  always #5 clk = ~clk;

  led_fade_pwm_driver #(.STEP_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .blue_req(blue_req), .amber_req(amber_req),
    .fade_en(fade_en), .led_blue_n(led_blue_n), .led_amber_n(led_amber_n),
    .fade_busy(fade_busy)
  );

  led_fade_pwm_driver #(.STEP_CYCLES(SC_S)) dut_slow (
    .clk(clk), .rst_n(slow_rst_n), .blue_req(slow_req), .amber_req(1'b0),
    .fade_en(1'b1), .led_blue_n(slow_blue_n), .led_amber_n(slow_amber_n),
    .fade_busy(slow_busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_edge();
    logic req[2];
    logic nled[2];
    logic nbusy;
    logic stp;
    int   l;
    req[0] = blue_req;
    req[1] = amber_req;
    if (!rst_n) begin
      m_pre = 0; m_pwm = 0; m_busy = 1'b0;
      for (int c = 0; c < 2; c++) begin
        m_lvl[c] = 0; m_st[c] = 0; m_led[c] = 1'b1;
      end
    end else begin
      stp   = (m_pre == SC - 1);
      nbusy = 1'b0;
      for (int c = 0; c < 2; c++) begin
        nled[c] = !((m_lvl[c] == 255) || (m_pwm < m_lvl[c]));
        if (m_st[c] == 1 || m_st[c] == 3) nbusy = 1'b1;
      end
      for (int c = 0; c < 2; c++) begin
        if (!fade_en) begin
          m_lvl[c] = req[c] ? 255 : 0;
          m_st[c]  = req[c] ? 2 : 0;
        end else begin
          l = m_lvl[c];
          if (stp && m_st[c] == 1 && l < 255) l = l + 1;
          if (stp && m_st[c] == 3 && l > 0)   l = l - 1;
          case (m_st[c])
            0: m_st[c] = req[c] ? 1 : 0;
            1: m_st[c] = !req[c] ? 3 : ((l == 255) ? 2 : 1);
            2: m_st[c] = req[c] ? 2 : 3;
            default: m_st[c] = req[c] ? 1 : ((l == 0) ? 0 : 3);
          endcase
          m_lvl[c] = l;
        end
        m_led[c] = nled[c];
      end
      m_busy = nbusy;
      m_pre  = stp ? 0 : m_pre + 1;
      m_pwm  = (m_pwm + 1) % 256;
    end
  endtask

  task automatic tick();
    logic [2:0] e;
    model_edge();
    sb_q.push_back({m_led[0], m_led[1], m_busy});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val("led_blue_n", led_blue_n, e[2]);
      check_val("led_amber_n", led_amber_n, e[1]);
      check_val("fade_busy", fade_busy, e[0]);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0; blue_req = 1'b0; amber_req = 1'b0;
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  task automatic ramp_to(input int ch, input int target);
    int n;
    n = 0;
    while (m_lvl[ch] != target && n < 2000) begin
      tick();
      n++;
    end
    check_val("ramp_reach", m_lvl[ch], target);
  endtask

  initial begin
    int n, cnt;
    rst_n = 1'b0; blue_req = 1'b1; amber_req = 1'b1; fade_en = 1'b1;
    slow_rst_n = 1'b0; slow_req = 1'b0;

    // Reset held with both requests active in fade mode.
    repeat (10) tick();
    check_val("rst_pin_blue", led_blue_n, 1);
    check_val("rst_pin_amber", led_amber_n, 1);
    check_val("rst_busy", fade_busy, 0);
    rst_n = 1'b1;
    tick();
    check_val("rel_level_blue", m_lvl[0], 0);
    tick();
    check_val("rel_pin_blue", led_blue_n, 1);

    // Hard mode on/off latency and steady-on.
    fade_en = 1'b0;
    do_reset(2);
    blue_req = 1'b1;
    tick();
    tick();
    check_val("hard_on_lat", led_blue_n, 0);
    cnt = 0;
    for (int i = 0; i < 512; i++) begin
      tick();
      if (led_blue_n == 1'b0) cnt++;
    end
    check_val("hard_on_steady", cnt, 512);
    blue_req = 1'b0;
    tick();
    check_val("hard_off_n1", led_blue_n, 0);
    tick();
    check_val("hard_off_n2", led_blue_n, 1);

    // Fade ramp on amber from OFF to ON.
    fade_en = 1'b1;
    do_reset(2);
    amber_req = 1'b1;
    n = 0;
    while (fade_busy == 1'b0 && n < 10) begin tick(); n++; end
    check_val("busy_rise_lat", n, 2);
    while (fade_busy == 1'b1 && n < 2000) begin tick(); n++; end
    check_val("ramp_len_ok", (n >= 1016 && n <= 1028), 1);
    check_val("ramp_level", m_lvl[1], 255);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (led_amber_n == 1'b0) cnt++;
    end
    check_val("duty_255", cnt, 256);

    // Mid-ramp reversal at level 100.
    do_reset(2);
    blue_req = 1'b1;
    ramp_to(0, 100);
    blue_req = 1'b0;
    n = 0;
    while (fade_busy == 1'b1 && n < 1000) begin tick(); n++; end
    check_val("fall_len_ok", (n >= 396 && n <= 408), 1);
    check_val("fall_pin", led_blue_n, 1);

    // fade -> hard switch mid-ramp at level 50.
    do_reset(2);
    blue_req = 1'b1;
    ramp_to(0, 50);
    fade_en = 1'b0;
    tick();
    tick();
    check_val("snap_pin", led_blue_n, 0);
    check_val("snap_busy", fade_busy, 0);

    // Reset pulse mid-ramp at level 50.
    fade_en = 1'b1;
    do_reset(2);
    blue_req = 1'b1;
    ramp_to(0, 50);
    rst_n = 1'b0;
    tick();
    check_val("rst_mid_pin", led_blue_n, 1);
    check_val("rst_mid_busy", fade_busy, 0);
    rst_n = 1'b1; blue_req = 1'b0;
    tick();
    tick();
    check_val("rst_mid_after", led_blue_n, 1);

    // Random request/mode traffic against the model.
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3)  blue_req  = ~blue_req;
      if ($urandom_range(0, 99) < 3)  amber_req = ~amber_req;
      if ($urandom_range(0, 199) == 0) fade_en  = ~fade_en;
      rst_n = ($urandom_range(0, 999) != 0);
      tick();
    end
    rst_n = 1'b1;

    // Duty at level 64 on the slow-step instance (level holds 300 cycles).
    blue_req = 1'b0; amber_req = 1'b0;
    slow_rst_n = 1'b1; slow_req = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 19460; k++) begin
      tick();
      if (k >= 19202 && k <= 19457 && slow_blue_n == 1'b0) cnt++;
    end
    check_val("duty_64", cnt, 64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
